gnr_attractor_ctrl: RTL and testbench
=====================================

# gnr_attractor_ctrl

Sequencer for a Boolean gene-regulatory-network node array that finds the attractor reached from a given initial state. It loads the initial state into every node, then clocks the slow (s0) and fast (s1) state copies in Floyd tortoise/hare fashion until the copies match. After a match it holds s0 and advances only s1 to measure the attractor period. It sits between the host/accelerator control registers and the node array, driving each node's `reset_nos`, `start_s0`, `start_s1` and `init_state` inputs.

## Interface
- `NODES`, default 8: number of network nodes; width of the state vectors.
- `CNT_W`, default 16: width of the step and period counters.
- `MAX_STEPS`, default 65535: timeout limit for the phase-1 step count and for the phase-2 period count; must be at most 2^CNT_W-1.

- `clk`  in  1  system clock; everything is sampled on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a search; sampled only in IDLE.
- `abort`  in  1  synchronous; returns the FSM to IDLE from any state, with no `done` pulse.
- `init_value`  in  NODES  initial network state; captured when `start` is accepted.
- `s0_vec`  in  NODES  concatenated node `erk_s0` outputs (slow copy).
- `s1_vec`  in  NODES  concatenated node `erk_s1` outputs (fast copy).
- `reset_nos`  out  1  load `init_state` into all nodes.
- `init_state`  out  NODES  per-node initial bit; holds the captured `init_value`.
- `start_s0`  out  1  advance the slow copy. Each node internally updates s0 on every second `start_s0` only, starting with the first pulse after `reset_nos`.
- `start_s1`  out  1  advance the fast copy by one step.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `timeout`  out  1  result flag: no attractor was resolved within `MAX_STEPS`.
- `steps`  out  CNT_W  number of phase-1 steps issued when the match was detected.
- `period`  out  CNT_W  attractor period in steps; 0 on timeout.

## Operation
- **States:** IDLE, LOAD, STEP, CMP, PSTEP, PCMP, DONE.
- **IDLE:** when `start`=1, capture `init_value` into `init_state`, clear the counters and the result flags, and go to LOAD.
- **LOAD:** assert `reset_nos` for one cycle, then go to STEP.
- **STEP:** assert `start_s0` and `start_s1` for one cycle, increment `steps`, then go to CMP.
- **CMP:** node registers are now updated.
  - If `steps`>=2 and `s0_vec`==`s1_vec`: go to PSTEP.
  - Else if `steps`==MAX_STEPS: set `timeout` and go to DONE.
  - Otherwise: go to STEP.
  - The comparison at `steps`=1 is skipped because both copies have advanced once and are trivially equal.
- **PSTEP:** assert `start_s1` only, increment `period`, then go to PCMP.
- **PCMP:**
  - If `s1_vec`==`s0_vec`: go to DONE.
  - Else if `period`==MAX_STEPS: set `timeout`, clear `period`, and go to DONE.
  - Otherwise: go to PSTEP.
- **DONE:** `done`=1 for one cycle, then go to IDLE.
- **Result holding:** `steps`, `period` and `timeout` hold their values through IDLE until the next accepted `start`.
- **Counter width:** counters saturate at MAX_STEPS; they never wrap.
- **Strobe exclusivity:** `reset_nos`, `start_s0` and `start_s1` are never asserted in the same cycle as each other, except that `start_s0` and `start_s1` are asserted together in STEP.

## Timing
- All outputs are flops or decoded directly from the state register, with no combinational path from any input.
- **Reset values:** state=IDLE; all strobes, `busy`, `done` and `timeout` = 0; `steps`=0, `period`=0, `init_state`=0. These apply immediately on `rst_n` falling, regardless of the clock.
- **Reset mid-operation:** the search is dropped and no `done` pulse is issued. The node array is left as-is; the next LOAD reinitialises it.
- **abort:**
  - Takes effect at the next edge and overrides every transition, including `start` in IDLE.
  - Strobes are low from the following cycle.
  - Results are left partially updated and are not valid.
- **start while busy:** ignored. `start` and `abort` asserted together in IDLE: abort wins, and the FSM stays in IDLE.
- **Cycle count:** each phase-1 step costs 2 cycles (STEP, CMP) and each phase-2 step costs 2 cycles (PSTEP, PCMP).
- **Latency example:** `start` accepted at edge E0 gives LOAD in cycle 1 and STEP in cycle 2. For a fixed point, the match occurs in CMP at cycle 5 and `done` is asserted in cycle 8. In general, `done` is asserted in cycle 1 + 2·`steps` + 2·`period` + 1.

## Test plan
- **Fixed point:** behavioural node model with F(x)=x, `init_value`=8'hA5 -> `steps`=2, `period`=1, `timeout`=0; `done` asserted exactly 8 cycles after start is accepted.
- **Period-2 attractor:** toggle map F(x)=~x, `init_value`=8'h00 -> `steps`=4, `period`=2; strobe sequence exactly LOAD, 4×STEP, 2×PSTEP.
- **Timeout:** `MAX_STEPS`=10 with a counter map F(x)=x+1 (period 256) -> `timeout`=1, `steps`=10, `period`=0, single `done` pulse.
- **abort:** assert `abort` during the third STEP -> FSM in IDLE at the next edge, `busy`=0 and strobes low from the following cycle, no `done`; a new `start` then completes normally.
- **Asynchronous reset:** drop `rst_n` mid-PSTEP between clock edges -> all outputs 0 immediately; after release, a fresh search gives correct results.
- **start while busy:** pulse `start` with a different `init_value` while `busy`=1 -> ignored; results match the first `init_value`.

Source files
------------

// File: rtl/gnr_attractor_ctrl.sv
// Attractor-search sequencer for a Boolean gene-regulatory-network node array.
// Floyd tortoise/hare search (phase 1), then period measurement on s1 alone (phase 2).
module gnr_attractor_ctrl #(
  parameter int NODES     = 8,
  parameter int CNT_W     = 16,
  parameter int MAX_STEPS = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [NODES-1:0] init_value,
  input  logic [NODES-1:0] s0_vec,
  input  logic [NODES-1:0] s1_vec,
  output logic             reset_nos,
  output logic [NODES-1:0] init_state,
  output logic             start_s0,
  output logic             start_s1,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] steps,
  output logic [CNT_W-1:0] period,
  output logic [2:0]       state_dbg
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] STEP  = 3'd2;
  localparam logic [2:0] CMP   = 3'd3;
  localparam logic [2:0] PSTEP = 3'd4;
  localparam logic [2:0] PCMP  = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STEPS);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

  logic [2:0] state;

  // Strobes and status decode straight from the state register: no input-to-output path.
  assign reset_nos = (state == LOAD);
  assign start_s0  = (state == STEP);
  assign start_s1  = (state == STEP) || (state == PSTEP);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      init_state <= '0;
      steps      <= '0;
      period     <= '0;
      timeout    <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            init_state <= init_value;
            steps      <= '0;
            period     <= '0;
            timeout    <= 1'b0;
            state      <= LOAD;
          end
        end
        LOAD: state <= STEP;
        STEP: begin
          if (steps != MAX_CNT) steps <= steps + ONE;
          state <= CMP;
        end
        CMP: begin
          // After one step both copies have advanced once and match trivially.
          if ((steps >= TWO) && (s0_vec == s1_vec)) begin
            state <= PSTEP;
          end else if (steps == MAX_CNT) begin
            timeout <= 1'b1;
            state   <= DONE;
          end else begin
            state <= STEP;
          end
        end
        PSTEP: begin
          if (period != MAX_CNT) period <= period + ONE;
          state <= PCMP;
        end
        PCMP: begin
          if (s1_vec == s0_vec) begin
            state <= DONE;
          end else if (period == MAX_CNT) begin
            timeout <= 1'b1;
            period  <= '0;
            state   <= DONE;
          end else begin
            state <= PSTEP;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Directed bench for gnr_attractor_ctrl: a behavioural node array closes the loop
// so each search runs against a known map F with hand-derived steps/period/latency.
module tb_gnr_attractor_ctrl;

  localparam int NODES = 8;
  localparam int CNT_W = 16;
  localparam int MAX   = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [NODES-1:0] init_value = '0;
  logic [NODES-1:0] s0_vec;
  logic [NODES-1:0] s1_vec;
  logic             reset_nos;
  logic [NODES-1:0] init_state;
  logic             start_s0;
  logic             start_s1;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] steps;
  logic [CNT_W-1:0] period;
  logic [2:0]       state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gnr_attractor_ctrl #(.NODES(NODES), .CNT_W(CNT_W), .MAX_STEPS(MAX)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .init_value(init_value), .s0_vec(s0_vec), .s1_vec(s1_vec),
    .reset_nos(reset_nos), .init_state(init_state),
    .start_s0(start_s0), .start_s1(start_s1),
    .busy(busy), .done(done), .timeout(timeout),
    .steps(steps), .period(period), .state_dbg(state_dbg)
  );

  // Node array model: 0 identity, 1 invert, 2 increment, 3 mod-3 counter in bits [1:0].
  logic [1:0]       mode = 2'd0;
  logic [NODES-1:0] m_s0 = '0;
  logic [NODES-1:0] m_s1 = '0;
  logic             m_par = 1'b0;

  function automatic logic [7:0] f_map(input logic [1:0] m, input logic [7:0] x);
    case (m)
      2'd0:    f_map = x;
      2'd1:    f_map = ~x;
      2'd2:    f_map = x + 8'd1;
      default: f_map = {x[7:2], (x[1:0] >= 2'd2) ? 2'd0 : x[1:0] + 2'd1};
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset_nos) begin
      m_s0  <= init_state;
      m_s1  <= init_state;
      m_par <= 1'b0;
    end else begin
      if (start_s0) begin
        m_par <= ~m_par;
        if (!m_par) m_s0 <= f_map(mode, m_s0);
      end
      if (start_s1) m_s1 <= f_map(mode, m_s1);
    end
  end

  assign s0_vec = m_s0;
  assign s1_vec = m_s1;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] init;
    bit         busy_start;
    int         exp_steps;
    int         exp_period;
    int         exp_to;
    int         exp_cyc;
  } vec_t;

  vec_t tbl[5];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_search(input int idx);
    vec_t v;
    int   n;
    int   c_load;
    int   c_step;
    int   c_pstep;
    int   viol;
    bit   got;
    v = tbl[idx];
    c_load = 0; c_step = 0; c_pstep = 0; viol = 0; got = 0;
    mode = v.mode;
    init_value = v.init;
    start = 1'b1;
    cyc();
    start = 1'b0;
    n = 1;
    while (n <= 200) begin
      if (v.busy_start && n == 3) begin
        start = 1'b1;
        init_value = ~v.init;
      end else begin
        start = 1'b0;
      end
      if (reset_nos) c_load++;
      if (start_s0 && start_s1) c_step++;
      if (start_s1 && !start_s0) c_pstep++;
      if ((reset_nos && (start_s0 || start_s1)) || (start_s0 && !start_s1)) viol++;
      if (done) begin
        got = 1;
        break;
      end
      cyc();
      n++;
    end
    start = 1'b0;
    check($sformatf("v%0d done_seen", idx), 32'(got), 32'd1);
    check($sformatf("v%0d latency", idx), 32'(n), 32'(v.exp_cyc));
    check($sformatf("v%0d steps", idx), 32'(steps), 32'(v.exp_steps));
    check($sformatf("v%0d period", idx), 32'(period), 32'(v.exp_period));
    check($sformatf("v%0d timeout", idx), 32'(timeout), 32'(v.exp_to));
    check($sformatf("v%0d init_state", idx), 32'(init_state), 32'(v.init));
    check($sformatf("v%0d load_cnt", idx), 32'(c_load), 32'd1);
    check($sformatf("v%0d step_cnt", idx), 32'(c_step), 32'(v.exp_steps));
    check($sformatf("v%0d pstep_cnt", idx), 32'(c_pstep), 32'(v.exp_period));
    check($sformatf("v%0d strobe_excl", idx), 32'(viol), 32'd0);
    cyc();
    check($sformatf("v%0d done_width", idx), 32'(done), 32'd0);
    check($sformatf("v%0d idle_busy", idx), 32'(busy), 32'd0);
    cyc();
    cyc();
    check($sformatf("v%0d steps_hold", idx), 32'(steps), 32'(v.exp_steps));
    check($sformatf("v%0d period_hold", idx), 32'(period), 32'(v.exp_period));
  endtask

  initial begin
    int k;
    int dcnt;
    bit found;

    //             mode  init   bsy steps per to cyc
    tbl[0] = '{2'd0, 8'hA5, 1'b0, 2,  1, 0, 8};
    tbl[1] = '{2'd1, 8'h00, 1'b0, 4,  2, 0, 14};
    tbl[2] = '{2'd2, 8'h00, 1'b0, 10, 0, 1, 22};
    tbl[3] = '{2'd3, 8'h00, 1'b0, 6,  3, 0, 20};
    tbl[4] = '{2'd1, 8'h3C, 1'b1, 4,  2, 0, 14};

    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_strobes", 32'({reset_nos, start_s0, start_s1, done}), 32'd0);
    check("rst_results", 32'({timeout, steps, period}), 32'd0);
    check("rst_init_state", 32'(init_state), 32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < 5; i++) run_search(i);

    // abort during the third STEP
    mode = 2'd2;
    init_value = 8'h00;
    start = 1'b1;
    cyc();
    start = 1'b0;
    k = 0;
    for (int i = 0; i < 50; i++) begin
      if (start_s0) k++;
      if (k == 3) break;
      cyc();
    end
    check("abort_reach_step3", 32'(k), 32'd3);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_strobes", 32'({reset_nos, start_s0, start_s1}), 32'd0);
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (done || busy) dcnt++;
      cyc();
    end
    check("abort_no_done", 32'(dcnt), 32'd0);
    start = 1'b1;
    abort = 1'b1;
    cyc();
    start = 1'b0;
    abort = 1'b0;
    check("abort_over_start", 32'(busy), 32'd0);
    cyc();
    run_search(0);

    // asynchronous reset mid-PSTEP
    mode = 2'd1;
    init_value = 8'h00;
    start = 1'b1;
    cyc();
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (start_s1 && !start_s0) begin
        found = 1;
        break;
      end
      cyc();
    end
    check("areset_reach_pstep", 32'(found), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("areset_busy", 32'(busy), 32'd0);
    check("areset_strobes", 32'({reset_nos, start_s0, start_s1, done}), 32'd0);
    check("areset_results", 32'({timeout, steps, period}), 32'd0);
    check("areset_init_state", 32'(init_state), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    run_search(1);
    run_search(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
